// File: rtl/sfifo.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// programmable almost-full/almost-empty flags, occupancy count and sticky
// overflow/underflow error flags. Storage is a simple dual-port RAM with one
// write port and one registered read port; all status outputs are registered.
module sfifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 7,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 2**ADDRESS_WIDTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;

    localparam logic [ADDRESS_WIDTH:0]   DEPTH_C  = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0]   AFULL_C  = (ADDRESS_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDRESS_WIDTH:0]   AEMPTY_C = (ADDRESS_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = (ADDRESS_WIDTH+1)'(1);
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE  = ADDRESS_WIDTH'(1);

    // Elaboration-time sanity checks on the configuration.
    generate
        if (ADDRESS_WIDTH < 2) begin : g_chk_aw
            $error("sfifo: ADDRESS_WIDTH must be at least 2");
        end
        if (!(AEMPTY_THRESH > 0 && AEMPTY_THRESH < AFULL_THRESH &&
              AFULL_THRESH <= 2**ADDRESS_WIDTH)) begin : g_chk_thr
            $error("sfifo: need 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
        end
    endgenerate

    // Storage and pointers.
    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;

    // FWFT bookkeeping: words still in RAM and whether dout holds the head word.
    // In standard mode these stay idle and are trimmed away.
    logic [ADDRESS_WIDTH:0]   mem_cnt;
    logic                     out_valid;

    // Next-state values.
    logic                     wr_ok;
    logic                     rd_ok;
    logic                     mem_rd;
    logic [ADDRESS_WIDTH:0]   count_nxt;
    logic [ADDRESS_WIDTH:0]   mem_cnt_nxt;
    logic                     out_valid_nxt;
    logic                     empty_nxt;
    logic                     full_nxt;
    logic                     afull_nxt;
    logic                     aempty_nxt;

    // Accept decisions, RAM read enable and next occupancy/flag values.
    always_comb begin
        wr_ok         = wr_en && !full;
        rd_ok         = rd_en && !empty;
        mem_rd        = 1'b0;
        count_nxt     = count;
        mem_cnt_nxt   = mem_cnt;
        out_valid_nxt = out_valid;
        empty_nxt     = empty;

        // Port-level occupancy: only an unbalanced accept changes it.
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase

        if (FWFT != 0) begin
            // Refill the output stage whenever it is empty or being popped.
            // mem_cnt is the pre-edge value, so a word written this edge is
            // never the one read this edge.
            mem_rd = (mem_cnt != '0) && (!out_valid || rd_ok);
            if (mem_rd) begin
                out_valid_nxt = 1'b1;
            end else if (rd_ok) begin
                out_valid_nxt = 1'b0;
            end
            case ({wr_ok, mem_rd})
                2'b10:   mem_cnt_nxt = mem_cnt + CNT_ONE;
                2'b01:   mem_cnt_nxt = mem_cnt - CNT_ONE;
                default: mem_cnt_nxt = mem_cnt;
            endcase
            empty_nxt = !out_valid_nxt;
        end else begin
            mem_rd    = rd_ok;
            empty_nxt = (count_nxt == '0);
        end

        full_nxt   = (count_nxt == DEPTH_C);
        afull_nxt  = (count_nxt >= AFULL_C);
        aempty_nxt = (count_nxt <= AEMPTY_C);
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Registered RAM read port driving dout; holds when no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (mem_rd) begin
            dout <= mem[rd_ptr];
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            mem_cnt      <= '0;
            out_valid    <= 1'b0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (mem_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count        <= count_nxt;
            mem_cnt      <= mem_cnt_nxt;
            out_valid    <= out_valid_nxt;
            empty        <= empty_nxt;
            full         <= full_nxt;
            almost_full  <= afull_nxt;
            almost_empty <= aempty_nxt;
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || (wr_en && full);
            underflow <= (underflow && !clr_err) || (rd_en && empty);
        end
    end

endmodule

// File: tb/tb_sfifo.sv
// Directed bench for sfifo: one standard-mode instance and one FWFT instance
// sharing clock and reset, with hand-computed expected values.
module tb_sfifo;

    localparam int DW = 32;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    // Standard-mode instance signals.
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;

    // FWFT instance signals.
    logic          f_wr_en = 1'b0;
    logic          f_rd_en = 1'b0;
    logic          f_clr_err = 1'b0;
    logic [DW-1:0] f_din = '0;
    logic [DW-1:0] f_dout;
    logic          f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [AW:0]   f_count;

    int n_tests = 0;
    int n_fail  = 0;

    sfifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FWFT(0),
            .AFULL_THRESH(124), .AEMPTY_THRESH(4)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    sfifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FWFT(1),
            .AFULL_THRESH(124), .AEMPTY_THRESH(4)) u_dut_fwft (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
        .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
        .underflow(f_underflow), .clr_err(f_clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values, asserted without a clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_dout", dout, 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);
        chk("rst_f_empty", 32'(f_empty), 1);
        tick();
        tick();
        rst = 1'b0;

        // Three writes then three reads, standard mode.
        wr_en = 1'b1; din = 32'h11;
        tick();
        chk("w1_empty", 32'(empty), 0);
        chk("w1_count", 32'(count), 1);
        din = 32'h22; tick();
        din = 32'h33; tick();
        wr_en = 1'b0;
        chk("w3_count", 32'(count), 3);
        rd_en = 1'b1;
        tick();
        chk("r1_dout", dout, 32'h11);
        chk("r1_count", 32'(count), 2);
        tick();
        chk("r2_dout", dout, 32'h22);
        tick();
        chk("r3_dout", dout, 32'h33);
        chk("r3_count", 32'(count), 0);
        chk("r3_empty", 32'(empty), 1);
        rd_en = 1'b0;

        // Fill 128 words with threshold checks on the way up.
        wr_en = 1'b1;
        for (int i = 0; i < 128; i++) begin
            din = i;
            tick();
            if (i + 1 == 4)   chk("up4_aempty", 32'(almost_empty), 1);
            if (i + 1 == 5)   chk("up5_aempty", 32'(almost_empty), 0);
            if (i + 1 == 123) chk("up123_afull", 32'(almost_full), 0);
            if (i + 1 == 124) chk("up124_afull", 32'(almost_full), 1);
            if (i + 1 == 127) chk("up127_full", 32'(full), 0);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 128);
        chk("fill_ovf0", 32'(overflow), 0);
        din = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 128);

        // Drain in order with threshold checks on the way down.
        rd_en = 1'b1;
        for (int k = 1; k <= 128; k++) begin
            tick();
            chk("drain_data", dout, 32'(k - 1));
            if (128 - k == 124) chk("dn124_afull", 32'(almost_full), 1);
            if (128 - k == 123) chk("dn123_afull", 32'(almost_full), 0);
            if (128 - k == 5)   chk("dn5_aempty", 32'(almost_empty), 0);
            if (128 - k == 4)   chk("dn4_aempty", 32'(almost_empty), 1);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);
        // One more read while empty: rejected, dout holds, underflow set.
        tick();
        rd_en = 1'b0;
        chk("unf_set", 32'(underflow), 1);
        chk("unf_dout_hold", dout, 32'h7F);
        chk("unf_count", 32'(count), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_unf", 32'(underflow), 0);

        // Simultaneous access when full.
        wr_en = 1'b1;
        for (int i = 0; i < 128; i++) begin
            din = 32'h200 + i;
            tick();
        end
        rd_en = 1'b1; din = 32'hBEEF;
        tick();
        wr_en = 1'b0;
        chk("fullrw_count", 32'(count), 127);
        chk("fullrw_ovf", 32'(overflow), 1);
        chk("fullrw_full", 32'(full), 0);
        chk("fullrw_dout", dout, 32'h200);
        for (int k = 0; k < 127; k++) tick();
        chk("fullrw_last", dout, 32'h27F);
        chk("fullrw_empty", 32'(empty), 1);

        // Simultaneous access when empty.
        wr_en = 1'b1; din = 32'h3C;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("emptyrw_count", 32'(count), 1);
        chk("emptyrw_unf", 32'(underflow), 1);
        chk("emptyrw_empty", 32'(empty), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr2_ovf", 32'(overflow), 0);
        chk("clr2_unf", 32'(underflow), 0);
        rd_en = 1'b1;
        tick();
        chk("emptyrw_data", dout, 32'h3C);
        chk("emptyrw_empty2", 32'(empty), 1);
        // Clear coinciding with a fresh error keeps the flag set.
        clr_err = 1'b1;
        tick();
        chk("clr_vs_err", 32'(underflow), 1);
        rd_en = 1'b0;
        tick();
        clr_err = 1'b0;
        chk("clr3_unf", 32'(underflow), 0);

        // FWFT: one-cycle prefetch after a write into an empty FIFO.
        f_wr_en = 1'b1; f_din = 32'hA5;
        tick();
        f_wr_en = 1'b0;
        chk("fw_n_empty", 32'(f_empty), 1);
        chk("fw_n_count", 32'(f_count), 1);
        tick();
        chk("fw_n1_empty", 32'(f_empty), 0);
        chk("fw_n1_dout", f_dout, 32'hA5);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        chk("fw_pop_empty", 32'(f_empty), 1);
        chk("fw_pop_count", 32'(f_count), 0);

        // FWFT: back-to-back pops without bubbles.
        f_wr_en = 1'b1;
        f_din = 32'hB1; tick();
        f_din = 32'hB2; tick();
        f_din = 32'hB3; tick();
        f_wr_en = 1'b0;
        chk("fw_head", f_dout, 32'hB1);
        chk("fw_cnt3", 32'(f_count), 3);
        f_rd_en = 1'b1;
        tick();
        chk("fw_pop1", f_dout, 32'hB2);
        tick();
        chk("fw_pop2", f_dout, 32'hB3);
        chk("fw_pop2_empty", 32'(f_empty), 0);
        tick();
        f_rd_en = 1'b0;
        chk("fw_pop3_empty", 32'(f_empty), 1);
        chk("fw_pop3_count", 32'(f_count), 0);

        // Asynchronous reset mid-burst at count 50.
        wr_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            din = 32'h100 + i;
            tick();
        end
        rd_en = 1'b1; din = 32'h1FF;
        tick();
        chk("burst_count", 32'(count), 50);
        chk("burst_dout", dout, 32'h100);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full", 32'(full), 0);
        chk("arst_aempty", 32'(almost_empty), 1);
        chk("arst_afull", 32'(almost_full), 0);
        chk("arst_dout", dout, 0);
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        wr_en = 1'b1; din = 32'h77;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("post_rst_data", dout, 32'h77);
        chk("post_rst_count", 32'(count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sfifo.md
Name: sfifo

Overview:
- Parametrised single-clock FIFO, the synchronous counterpart of the dual-clock FIFO used on the PCIe config-space paths.
- Used where producer and consumer share one clock, e.g. buffering FIFO_PCIECFG_T words between the config request decoder and the responder.
- Adds two read modes (standard / first-word-fall-through), programmable almost-full/almost-empty flags, an occupancy count, and sticky overflow/underflow error flags.

Parameters:
DATA_WIDTH, 32, width of din/dout in bits (set to $bits(FIFO_PCIECFG_T) for config paths)
ADDRESS_WIDTH, 7, log2 of storage depth; DEPTH = 2**ADDRESS_WIDTH words
FWFT, 0, 0 = standard read (data one cycle after rd_en), 1 = first-word-fall-through
AFULL_THRESH, DEPTH-4, almost_full asserts when count >= AFULL_THRESH
AEMPTY_THRESH, 4, almost_empty asserts when count <= AEMPTY_THRESH

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write request
din  in  DATA_WIDTH  write data
rd_en  in  1  read request (pop)
dout  out  DATA_WIDTH  read data
full  out  1  no free slot
empty  out  1  no readable word (FWFT: dout invalid)
almost_full  out  1  count >= AFULL_THRESH
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  ADDRESS_WIDTH+1  words accepted and not yet popped, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async assert, any cycle including mid-transfer):
  - pointers = 0, count = 0, dout = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - overflow = 0, underflow = 0
  - stored data discarded.
- Reset release: synchronous to clk; the first edge after deassert can accept a write.
- Write: accepted at an edge iff wr_en && !full. Write pointer wraps DEPTH-1 -> 0.
- Read: accepted at an edge iff rd_en && !empty. Read pointer wraps DEPTH-1 -> 0.
- Rejected accesses:
  - Rejected write: data dropped, overflow set.
  - Rejected read: no pointer change, dout holds, underflow set.
  - Both flags are sticky until clr_err or rst. If clr_err and a new error occur in the same cycle, the flag stays set.
- Count per edge: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
- Flag timing: full, empty, almost_full, almost_empty and count are registered and reflect the post-edge state; they are never combinational from wr_en/rd_en.
- Simultaneous access:
  - When full with wr_en && rd_en: read accepted, write rejected (overflow set), count = DEPTH-1.
  - When empty with wr_en && rd_en: write accepted, read rejected (underflow set).
- Standard mode (FWFT=0):
  - dout updates the edge after an accepted read and holds otherwise.
  - Write at edge N into an empty FIFO: empty = 0 after edge N, so the word is readable at edge N+1.
- FWFT mode (FWFT=1):
  - Head word is presented on dout whenever empty = 0; rd_en acknowledges and pops it.
  - Write at edge N into an empty FIFO: dout valid and empty = 0 after edge N+1 (one prefetch stage).
  - The word held in the output stage counts in count; total capacity stays DEPTH.
  - Consecutive rd_en at every edge yields a new word per cycle with no bubbles while count >= 2.
- Storage: inferred RAM with one write port and one registered read port. No read-during-write hazard is visible at ports: a word written at edge N is never the one read at edge N.
- Parameter checks (elaboration assertions): ADDRESS_WIDTH >= 2, and 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH.

Test Plan:
- Reset, then write 0x11,0x22,0x33 on consecutive cycles (FWFT=0) and read 3 -> dout 0x11,0x22,0x33, each the cycle after its rd_en; count 3->0; empty = 1 after the last read.
- Fill 128 words (ADDRESS_WIDTH=7) -> full = 1 and count = 128 after the 128th write. Write 0xDEAD -> overflow = 1 and 0xDEAD is never read back. Drain -> data 0..127 in order, pointers wrap.
- With FWFT=1, write 0xA5 at edge N -> empty = 0 and dout = 0xA5 after N+1. rd_en for one cycle -> empty = 1, count = 0.
- With full, assert wr_en && rd_en -> count = 127, overflow = 1. With empty, assert both -> count = 1, underflow = 1. Pulse clr_err -> both flags 0.
- With AFULL_THRESH=124 and AEMPTY_THRESH=4: writes cause almost_empty to drop at count 5 and almost_full to rise at count 124; reads reverse both at the same counts.
- Assert rst asynchronously mid-burst at count 50 -> all outputs take their reset values immediately without a clk edge. A write after release reads back as the first word.
